// File: rtl/exe_pkg.sv
// exe_pkg: shared constants for the execute stage.
//   - ALU command encodings (exe_cmd)
//   - barrel shifter type codes (shift_operand[6:5])
//   - bit positions of the {N,Z,C,V} status nibble
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

endpackage

// File: rtl/exe_val2_gen.sv
// exe_val2_gen: builds the second ALU operand (Val2).
// Priority: immediate rotate > memory offset > register operand.
// Optional feature macro: EXE_BARREL_SHIFT_EN -- when defined, the register
// form applies LSL/LSR/ASR/ROR by shift_operand[11:7]; otherwise val_rm is
// passed through unshifted.
// Ports:
//   i_imm            immediate form select
//   i_mem_en         load/store instruction (offset form)
//   i_shift_operand  12-bit operand-2 field
//   i_val_rm         register operand Rm
//   o_val2           resulting Val2
import exe_pkg::*;

module exe_val2_gen (
    input  logic        i_imm,
    input  logic        i_mem_en,
    input  logic [11:0] i_shift_operand,
    input  logic [31:0] i_val_rm,
    output logic [31:0] o_val2
);

    logic [4:0]  w_rot;
    logic [63:0] w_imm_dbl;
    logic [31:0] w_imm_rot;
    logic [31:0] w_reg_val;

    // Rotating right = shifting a doubled copy and keeping the low word.
    assign w_rot     = {i_shift_operand[11:8], 1'b0};
    assign w_imm_dbl = {24'b0, i_shift_operand[7:0], 24'b0, i_shift_operand[7:0]} >> w_rot;
    assign w_imm_rot = w_imm_dbl[31:0];

`ifdef EXE_BARREL_SHIFT_EN
    logic [4:0]  w_shamt;
    logic [63:0] w_rm_dbl;

    assign w_shamt  = i_shift_operand[11:7];
    assign w_rm_dbl = {i_val_rm, i_val_rm} >> w_shamt;

    // shamt=0 falls out naturally as "no shift" for every type.
    always_comb begin
        w_reg_val = i_val_rm;
        case (i_shift_operand[6:5])
            SH_LSL:  w_reg_val = i_val_rm << w_shamt;
            SH_LSR:  w_reg_val = i_val_rm >> w_shamt;
            SH_ASR:  w_reg_val = $unsigned($signed(i_val_rm) >>> w_shamt);
            SH_ROR:  w_reg_val = w_rm_dbl[31:0];
            default: w_reg_val = i_val_rm;
        endcase
    end
`else
    assign w_reg_val = i_val_rm;
`endif

    always_comb begin
        if (i_imm)
            o_val2 = w_imm_rot;
        else if (i_mem_en)
            o_val2 = {20'b0, i_shift_operand};
        else
            o_val2 = w_reg_val;
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage pipeline.
// Computes ALU result, NZCV status and branch target combinationally,
// registers the EX/MEM fields, and flags RAW hazards for the ID stage.
// Optional feature macro: EXE_BARREL_SHIFT_EN (register-operand shifter,
// see exe_val2_gen).
// Ports:
//   clk, rst                clock, async active-low reset
//   exe_cmd, wb_en, mem_r_en, mem_w_en, pc, val_rn, val_rm, imm,
//   shift_operand, signed_imm_24, sr, dest   ID/EX inputs
//   src1, src2, two_src     ID-stage sources for hazard detection
//   alu_result, br_addr, status, hazard_detected   combinational outputs
//   wb_en_q, mem_r_en_q, mem_w_en_q, alu_result_q, st_val_q, dest_q  EX/MEM
import exe_pkg::*;

module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  exe_cmd,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] pc,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm_24,
    input  logic [3:0]  sr,
    input  logic [3:0]  dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    output logic [31:0] alu_result,
    output logic [31:0] br_addr,
    output logic [3:0]  status,
    output logic        wb_en_q,
    output logic        mem_r_en_q,
    output logic        mem_w_en_q,
    output logic [31:0] alu_result_q,
    output logic [31:0] st_val_q,
    output logic [3:0]  dest_q,
    output logic        hazard_detected
);

    logic [31:0] w_val2;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;
    logic        w_known;

    exe_val2_gen u_val2 (
        .i_imm           (imm),
        .i_mem_en        (mem_r_en | mem_w_en),
        .i_shift_operand (shift_operand),
        .i_val_rm        (val_rm),
        .o_val2          (w_val2)
    );

    // Subtracts are done as Rn + ~Val2 + carry-in so the 33rd bit is the
    // ARM-style "no borrow" carry directly.
    always_comb begin
        w_sum   = 33'd0;
        w_res   = 32'd0;
        w_c     = sr[ST_C];
        w_v     = sr[ST_V];
        w_known = 1'b1;
        case (exe_cmd)
            CMD_MOV: w_res = w_val2;
            CMD_MVN: w_res = ~w_val2;
            CMD_ADD, CMD_ADC: begin
                w_sum = {1'b0, val_rn} + {1'b0, w_val2}
                      + {32'b0, (exe_cmd == CMD_ADC) & sr[ST_C]};
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (val_rn[31] == w_val2[31]) && (w_res[31] != val_rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                w_sum = {1'b0, val_rn} + {1'b0, ~w_val2}
                      + {32'b0, (exe_cmd == CMD_SUB) | sr[ST_C]};
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (val_rn[31] != w_val2[31]) && (w_res[31] != val_rn[31]);
            end
            CMD_AND: w_res = val_rn & w_val2;
            CMD_ORR: w_res = val_rn | w_val2;
            CMD_EOR: w_res = val_rn ^ w_val2;
            default: w_known = 1'b0;
        endcase
    end

    assign alu_result = w_res;
    assign status     = w_known ? {w_res[31], (w_res == 32'd0), w_c, w_v} : sr;
    assign br_addr    = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

    // EX/MEM pipeline register
    logic        r_wb_en;
    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic [31:0] r_alu_result;
    logic [31:0] r_st_val;
    logic [3:0]  r_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_mem_w_en   <= 1'b0;
            r_alu_result <= 32'd0;
            r_st_val     <= 32'd0;
            r_dest       <= 4'd0;
        end else begin
            r_wb_en      <= wb_en;
            r_mem_r_en   <= mem_r_en;
            r_mem_w_en   <= mem_w_en;
            r_alu_result <= w_res;
            r_st_val     <= val_rm;
            r_dest       <= dest;
        end
    end

    assign wb_en_q      = r_wb_en;
    assign mem_r_en_q   = r_mem_r_en;
    assign mem_w_en_q   = r_mem_w_en;
    assign alu_result_q = r_alu_result;
    assign st_val_q     = r_st_val;
    assign dest_q       = r_dest;

    // RAW hazard: any ID source matching a pending EX or MEM writeback.
    logic w_hz_src1_ex;
    logic w_hz_src1_mem;
    logic w_hz_src2_ex;
    logic w_hz_src2_mem;

    assign w_hz_src1_ex  = (src1 == dest)   && wb_en;
    assign w_hz_src1_mem = (src1 == r_dest) && r_wb_en;
    assign w_hz_src2_ex  = two_src && (src2 == dest)   && wb_en;
    assign w_hz_src2_mem = two_src && (src2 == r_dest) && r_wb_en;

    assign hazard_detected = w_hz_src1_ex | w_hz_src1_mem | w_hz_src2_ex | w_hz_src2_mem;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  exe_cmd;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] pc, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  sr, dest, src1, src2;
    logic        two_src;
    logic [31:0] alu_result, br_addr, alu_result_q, st_val_q;
    logic [3:0]  status, dest_q;
    logic        wb_en_q, mem_r_en_q, mem_w_en_q, hazard_detected;

    execute_stage dut (
        .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc(pc), .val_rn(val_rn),
        .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .sr(sr), .dest(dest), .src1(src1),
        .src2(src2), .two_src(two_src), .alu_result(alu_result),
        .br_addr(br_addr), .status(status), .wb_en_q(wb_en_q),
        .mem_r_en_q(mem_r_en_q), .mem_w_en_q(mem_w_en_q),
        .alu_result_q(alu_result_q), .st_val_q(st_val_q), .dest_q(dest_q),
        .hazard_detected(hazard_detected)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] br;
        logic [3:0]  st;
        logic        hz;
        logic        wb_q;
        logic        mr_q;
        logic        mw_q;
        logic [31:0] alu_q;
        logic [31:0] st_q;
        logic [3:0]  dest_q;
    } exp_t;

    exp_t sb[$];
    exp_t qm;          // model of what the EX/MEM register holds
    int   checks = 0;
    int   errors = 0;
    logic tb_vld = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        if (r == 0) return x;
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [31:0] m_val2();
        if (imm) return ror32({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
        if (mem_r_en || mem_w_en) return {20'b0, shift_operand};
`ifdef EXE_BARREL_SHIFT_EN
        begin
            int sh = int'(shift_operand[11:7]);
            case (shift_operand[6:5])
                2'b00:   return val_rm << sh;
                2'b01:   return val_rm >> sh;
                2'b10:   return $unsigned($signed(val_rm) >>> sh);
                default: return ror32(val_rm, sh);
            endcase
        end
`else
        return val_rm;
`endif
    endfunction

    function automatic void m_alu(input logic [31:0] b, output logic [31:0] r,
                                  output logic [3:0] st);
        logic [31:0] a = val_rn;
        logic [63:0] u;
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        longint s = 0;
        logic cin = sr[1];
        logic c = sr[1];
        logic v = sr[0];
        logic arith = 1'b0;
        logic bw = ~cin;
        r = 32'd0;
        case (exe_cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010: begin u = {32'b0, a} + {32'b0, b}; r = u[31:0]; c = u[32]; s = sa + sb_; arith = 1; end
            4'b0011: begin u = {32'b0, a} + {32'b0, b} + {63'b0, cin}; r = u[31:0]; c = u[32];
                           s = sa + sb_ + longint'(cin); arith = 1; end
            4'b0100: begin r = a - b; c = (a >= b); s = sa - sb_; arith = 1; end
            4'b0101: begin r = a - b - {31'b0, bw}; c = ({32'b0, a} >= {32'b0, b} + {63'b0, bw});
                           s = sa - sb_ - longint'(bw); arith = 1; end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: begin st = sr; return; end
        endcase
        if (arith) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        st = {r[31], r == 32'd0, c, v};
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (tb_vld) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("alu_result",      alu_result,           e.alu);
                chk("br_addr",         br_addr,              e.br);
                chk("status",          {28'b0, status},      {28'b0, e.st});
                chk("hazard_detected", {31'b0, hazard_detected}, {31'b0, e.hz});
                chk("ctrl_q",          {29'b0, wb_en_q, mem_r_en_q, mem_w_en_q},
                                       {29'b0, e.wb_q, e.mr_q, e.mw_q});
                chk("alu_result_q",    alu_result_q,         e.alu_q);
                chk("st_val_q",        st_val_q,             e.st_q);
                chk("dest_q",          {28'b0, dest_q},      {28'b0, e.dest_q});
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs are set just after a rising edge; expectation pushed, checked at
    // the falling edge, and the register model advanced at the next rising edge.
    task automatic step();
        exp_t e;
        logic [31:0] r;
        logic [3:0] st;
        if (!rst) qm = '0;
        m_alu(m_val2(), r, st);
        e = qm;
        e.alu = r;
        e.st  = st;
        e.br  = pc + 32'(signed'({signed_imm_24, 2'b00}));
        e.hz  = (wb_en && (src1 == dest || (two_src && src2 == dest))) ||
                (qm.wb_q && (src1 == qm.dest_q || (two_src && src2 == qm.dest_q)));
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (rst) begin
            qm.wb_q = wb_en; qm.mr_q = mem_r_en; qm.mw_q = mem_w_en;
            qm.alu_q = r; qm.st_q = val_rm; qm.dest_q = dest;
        end else qm = '0;
        #1;
    endtask

    task automatic rand_inputs();
        exe_cmd = 4'($urandom_range(0, 15));
        wb_en = 1'($urandom); mem_r_en = 1'($urandom); mem_w_en = 1'($urandom);
        if ($urandom_range(0, 1) == 0) begin mem_r_en = 0; mem_w_en = 0; end
        pc = $urandom; val_rn = $urandom; val_rm = $urandom;
        if ($urandom_range(0, 3) == 0) val_rm = 32'h8000_0000 | $urandom_range(0, 15);
        imm = 1'($urandom); shift_operand = 12'($urandom);
        signed_imm_24 = 24'($urandom); sr = 4'($urandom);
        dest = 4'($urandom_range(0, 3)); src1 = 4'($urandom_range(0, 3));
        src2 = 4'($urandom_range(0, 3)); two_src = 1'($urandom);
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic im, input logic [11:0] so);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im; shift_operand = so;
        mem_r_en = 0; mem_w_en = 0; sr = 4'b0000;
    endtask

    initial begin
        qm = '0;
        rst = 1'b0;
        rand_inputs();
        wb_en = 1; dest = 4'd7;
        @(posedge clk); #1;
        tb_vld = 1'b1;
        // reset held with nonzero inputs: registered fields stay 0
        repeat (3) begin rand_inputs(); val_rm = 32'hDEAD_BEEF; step(); end
        // release: ADD 5 + imm 3
        rst = 1'b1;
        set_op(4'b0010, 32'd5, 32'd0, 1'b1, 12'h003);
        wb_en = 0; two_src = 0; dest = 0; src1 = 1; src2 = 2;
        pc = 32'h100; signed_imm_24 = 24'hFFFFFE;   // br_addr = 0xF8
        step();
        step();                                      // alu_result_q = 8
        set_op(4'b0001, 32'd0, 32'd0, 1'b1, 12'h1FF); step();            // 0xC000003F
        set_op(4'b0100, 32'd3, 32'd0, 1'b1, 12'h003); step();            // 0, Z C
        set_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 12'h000); step();    // overflow
        set_op(4'b0001, 32'd0, 32'h8000_0000, 1'b0, 12'h0C0); step();    // ASR 1
        set_op(4'b0101, 32'd0, 32'd0, 1'b1, 12'h000); step();            // SBC 0-0-1
        set_op(4'b1111, 32'd1, 32'd1, 1'b0, 12'h000); sr = 4'b1010; step(); // unknown op
        mem_w_en = 1; set_op(4'b0010, 32'h1000, 32'h55, 1'b0, 12'hFFC); mem_w_en = 1; step();
        // hazards
        mem_w_en = 0;
        dest = 3; wb_en = 1; src1 = 3; src2 = 0; two_src = 0; step();
        dest = 5; wb_en = 0; src1 = 3; step();          // via dest_q
        wb_en = 0; dest = 3; src1 = 1; step();          // all clear
        src2 = 3; two_src = 0; wb_en = 1; step();
        two_src = 1; step();
        // mid-operation asynchronous reset
        rst = 1'b0; step(); rst = 1'b1;
        // random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 49) != 0);
            step();
        end
        rst = 1'b1;
        tb_vld = 1'b0;
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
